// File: rtl/seq_onehot_encoder.sv
// rtl/seq_onehot_encoder.sv - iterative N-to-log2(N) encoder emitting one set-bit index per handshake
module seq_onehot_encoder #(
   parameter int N         = 64,
   parameter int IDX_W     = 6,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             done,
   output logic [IDX_W:0]   count
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FIN} state_t;

   localparam logic [IDX_W:0] COUNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   state_t           r_state;
   logic [N-1:0]     r_pending;
   logic [IDX_W:0]   r_count;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_done;

   logic [IDX_W-1:0] w_idx;
   logic [N-1:0]     w_next;

   // Priority pick: the loop order decides which set bit wins (last write wins).
   always_comb begin
      w_idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < N; i++)
            if (r_pending[i]) w_idx = IDX_W'(i);
      end else begin
         for (int i = N - 1; i >= 0; i--)
            if (r_pending[i]) w_idx = IDX_W'(i);
      end
   end

   assign w_next = r_pending & ~(N'(1) << w_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pending   <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_pending  <= in;
                  r_count    <= '0;
                  r_in_ready <= 1'b0;
                  if (in != '0) begin
                     r_state     <= S_SCAN;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (out_ready) begin
                  r_pending <= w_next;
                  r_count   <= r_count + COUNT_ONE;
                  if (w_next == '0) begin
                     r_state     <= S_FIN;
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               r_state    <= S_IDLE;
               r_done     <= 1'b0;
               r_in_ready <= 1'b1;
            end
            default: begin
               r_state     <= S_IDLE;
               r_pending   <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   // Pending is empty whenever out_valid is low, so the mask only guarantees a clean 0.
   assign out_idx   = r_out_valid ? w_idx : '0;
   assign out_valid = r_out_valid;
   assign in_ready  = r_in_ready;
   assign done      = r_done;
   assign count     = r_count;

endmodule

// File: tb/tb_seq_onehot_encoder.sv
// tb/tb_seq_onehot_encoder.sv - randomized and directed check of seq_onehot_encoder in both scan orders
module tb_seq_onehot_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_v = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, done;
   logic [5:0]  out_idx;
   logic [6:0]  count;
   logic        in_ready_m, out_valid_m, done_m;
   logic [5:0]  out_idx_m;
   logic [6:0]  count_m;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_onehot_encoder #(.N(64), .IDX_W(6), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst(rst), .in(in_v), .in_valid(in_valid), .in_ready(in_ready),
      .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .count(count)
   );

   seq_onehot_encoder #(.N(64), .IDX_W(6), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .in(in_v), .in_valid(in_valid), .in_ready(in_ready_m),
      .out_idx(out_idx_m), .out_valid(out_valid_m), .out_ready(out_ready),
      .done(done_m), .count(count_m)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_after_done();
      chk("post_done_done", done, 0);
      chk("post_done_in_ready", in_ready, 1);
      chk("post_done_out_valid", out_valid, 0);
      chk("post_done_m_in_ready", in_ready_m, 1);
   endtask

   // Reference: the set-bit positions of v in ascending order; MSB-first order is the reverse.
   task automatic run_vec(input logic [63:0] v, input int stall, input bit rnd, input bit inject);
      int q[$];
      int k, cyc, n;
      logic [63:0] acc;
      logic rdy;
      for (int i = 0; i < 64; i++) if (v[i]) q.push_back(i);
      n = q.size();
      chk("load_in_ready", in_ready, 1);
      in_v      = v;
      in_valid  = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      in_valid = 1'b0;
      k = 0; cyc = 0; acc = '0;
      while (k < n && cyc < 2000) begin
         chk("scan_out_valid", out_valid, 1);
         chk("scan_out_idx", out_idx, q[k]);
         chk("scan_out_idx_msb", out_idx_m, q[n-1-k]);
         chk("scan_in_ready", in_ready, 0);
         chk("scan_done", done, 0);
         rdy = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         out_ready = rdy;
         in_valid  = inject && ($urandom_range(0, 3) == 0);
         in_v      = {$urandom, $urandom};
         if (rdy) acc = acc | (64'd1 << out_idx);
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      chk("scan_budget", k, n);
      in_valid = 1'b0;
      chk("fin_done", done, 1);
      chk("fin_count", count, n);
      chk("fin_done_msb", done_m, 1);
      chk("fin_count_msb", count_m, n);
      chk("fin_out_valid", out_valid, 0);
      chk("fin_in_ready", in_ready, 0);
      chk("decoder_or_back", acc, v);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_idle_after_done();
   endtask

   initial begin
      logic [63:0] rv;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_out_idx", out_idx, 0);
      rst = 1'b0;
      @(negedge clk);

      run_vec(64'h0000_0000_0000_0005, 0, 1'b0, 1'b0);
      run_vec({64{1'b1}}, 0, 1'b0, 1'b0);
      run_vec(64'h8000_0000_0001_0000, 5, 1'b0, 1'b0);
      run_vec(64'h0, 0, 1'b0, 1'b0);
      run_vec(64'h8000_0000_0000_0001, 0, 1'b0, 1'b0);
      run_vec(64'h0000_00F0_0F00_1234, 0, 1'b0, 1'b1);

      // Reset in the middle of a scan: three indices out, then abort.
      in_v = 64'hFF; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_idx", out_idx, i);
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_count", count, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end

      for (int t = 0; t < 25; t++) begin
         rv = {$urandom, $urandom};
         if (t % 3 == 1) rv = rv & {$urandom, $urandom} & {$urandom, $urandom};
         if (t % 7 == 3) rv = 64'h0;
         run_vec(rv, $urandom_range(0, 3), 1'b1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
